// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first.
// Start/done handshake; divide-by-zero short-circuits straight to DONE.
module seq_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one restoring step per cycle, counter counts down to 0
    // DONE  | one-cycle result strobe; start accepted here as in IDLE
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] shreg;
    logic [DIVISOR_W-1:0]  dsr;
    logic [DIVISOR_W-1:0]  pr;
    logic [DIVISOR_W-1:0]  pr_nxt;
    logic [DIVISOR_W:0]    pr_ext;
    logic                  ge;
    logic                  accept;
    logic                  zero_div;
    logic                  last_step;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign zero_div  = (divisor == '0);
    assign last_step = (state == RUN) && (cnt == '0);

    // Shifted partial remainder is one bit wider than the divisor so the
    // compare never overflows; after a subtract the result fits DIVISOR_W.
    assign pr_ext = {pr, shreg[DIVIDEND_W-1]};
    assign ge     = (pr_ext >= {1'b0, dsr});
    assign pr_nxt = ge ? (pr_ext[DIVISOR_W-1:0] - dsr) : pr_ext[DIVISOR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = zero_div ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (accept) begin
                    state_nxt = zero_div ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The dividend register doubles as the quotient: each step shifts one
    // dividend bit out of the top and one quotient bit in at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            shreg       <= '0;
            dsr         <= '0;
            pr          <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept && !zero_div) begin
                cnt   <= CNT_W'(DIVIDEND_W - 1);
                shreg <= dividend;
                dsr   <= divisor;
                pr    <= '0;
            end else if (state == RUN) begin
                cnt   <= cnt - 1'b1;
                shreg <= {shreg[DIVIDEND_W-2:0], ge};
                pr    <= pr_nxt;
            end

            if (accept && zero_div) begin
                quotient    <= '1;
                remainder   <= '0;
                div_by_zero <= 1'b1;
            end else if (last_step) begin
                quotient    <= {shreg[DIVIDEND_W-2:0], ge};
                remainder   <= pr_nxt;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_divider;

    localparam int DW = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [SW-1:0] divisor = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;

    seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dvd;
        int dsr;
        int q;
        int r;
        int z;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int expv);
        n_total++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cyc);
    endtask

    // Called at a negedge; the start is taken at the following posedge.
    task automatic issue(input int a, input int b, input int q, input int r, input int z);
        exp_t e;
        e.dvd = a;
        e.dsr = b;
        e.q   = q;
        e.r   = r;
        e.z   = z;
        e.cyc = cyc + 1 + ((b == 0) ? 0 : DW);
        if (b != 0) begin
            busy_lo = cyc + 1;
            busy_hi = cyc + DW;
        end
        sb.push_back(e);
        start    = 1'b1;
        dividend = DW'(a);
        divisor  = SW'(b);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        chk("done_seen", int'(seen), 1);
    endtask

    // Monitor
    initial begin
        int hq = 0;
        int hr = 0;
        int hz = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hq = 0;
                hr = 0;
                hz = 0;
                continue;
            end
            chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("quotient", int'(quotient), e.q);
                    chk("remainder", int'(remainder), e.r);
                    chk("div_by_zero", int'(div_by_zero), e.z);
                    if (e.dsr != 0) begin
                        chk("invariant", int'(quotient) * e.dsr + int'(remainder), e.dvd);
                        chk("rem_lt_div", int'(int'(remainder) < e.dsr), 1);
                    end
                    hq = e.q;
                    hr = e.r;
                    hz = e.z;
                end
            end else begin
                chk("hold_quotient", int'(quotient), hq);
                chk("hold_remainder", int'(remainder), hr);
                chk("hold_div_by_zero", int'(div_by_zero), hz);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int nd;
        #1 rst = 1'b1;
        #1;
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_div_by_zero", int'(div_by_zero), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(225, 15, 15, 0, 0);
        wait_done();
        repeat (2) @(negedge clk);

        // second start lands in the DONE cycle of the first
        issue(100, 7, 14, 2, 0);
        wait_done();
        issue(5, 9, 0, 5, 0);
        wait_done();
        @(negedge clk);

        issue(255, 1, 255, 0, 0);
        wait_done();
        repeat (3) @(negedge clk);
        issue(0, 13, 0, 0, 0);
        wait_done();
        @(negedge clk);

        issue(200, 0, 255, 0, 1);
        wait_done();
        issue(9, 2, 4, 1, 0);
        wait_done();
        repeat (2) @(negedge clk);

        // mid-RUN start must be ignored, then async reset aborts the divide
        issue(100, 7, 14, 2, 0);
        @(negedge clk);
        start    = 1'b1;
        dividend = DW'(50);
        divisor  = SW'(5);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        sb.delete();
        busy_lo = 1;
        busy_hi = 0;
        #1;
        chk("midrst_quotient", int'(quotient), 0);
        chk("midrst_remainder", int'(remainder), 0);
        chk("midrst_div_by_zero", int'(div_by_zero), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_done_after_rst", nd, 0);
        issue(50, 5, 10, 0, 0);
        wait_done();

        // exhaustive non-zero operand sweep, issued back to back
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                issue(a, b, a / b, a % b, 0);
                wait_done();
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
